// File: rtl/alu_system_control_unit.sv
// Hardwired fetch/decode/execute sequencer driving the 8-bit ALUSystem datapath.
// Optional single-step gating of F0 is enabled with `define CU_SINGLE_STEP_EN.
module alu_system_control_unit (
  input  logic        Clock,
  input  logic        Reset,
`ifdef CU_SINGLE_STEP_EN
  input  logic        Step,
`endif
  input  logic [15:0] IR_Out,
  input  logic        Z,
  output logic [2:0]  RF_O1Sel,
  output logic [2:0]  RF_O2Sel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutASel,
  output logic [1:0]  ARF_OutBSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_FunSel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  State,
  output logic        InstrDone
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_E0   = 3'd3,
    S_E1   = 3'd4,
    S_E2   = 3'd5,
    S_E3   = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [3:0] opcode;
  logic [2:0] rd_sel, rs_sel;
  logic [3:0] rd_onehot;
  logic [3:0] alu_code;
  logic       is_alu_op;
  logic       unused_imm;

  assign opcode     = IR_Out[15:12];
  assign rd_sel     = {1'b1, IR_Out[11:10]};
  assign rs_sel     = {1'b1, IR_Out[9:8]};
  assign rd_onehot  = 4'b1000 >> IR_Out[11:10];
  assign is_alu_op  = (opcode >= 4'h3) && (opcode <= 4'hB);
  assign unused_imm = ^IR_Out[7:0];
  assign State      = state_q;

  always_comb begin
    case (opcode)
      4'h3:    alu_code = 4'b0001;
      4'h4:    alu_code = 4'b0100;
      4'h5:    alu_code = 4'b0101;
      4'h6:    alu_code = 4'b0111;
      4'h7:    alu_code = 4'b1000;
      4'h8:    alu_code = 4'b1010;
      4'h9:    alu_code = 4'b0011;
      4'hA:    alu_code = 4'b1011;
      4'hB:    alu_code = 4'b1100;
      default: alu_code = 4'b0000;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    RF_O1Sel    = '0;
    RF_O2Sel    = '0;
    RF_FunSel   = '0;
    RF_RSel     = '0;
    RF_TSel     = '0;
    ALU_FunSel  = '0;
    ARF_OutASel = '0;
    ARF_OutBSel = '1;
    ARF_FunSel  = '0;
    ARF_RSel    = '0;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_FunSel   = '0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = '0;
    MuxBSel     = '0;
    MuxCSel     = 1'b0;
    InstrDone   = 1'b0;
    state_d     = state_q;

    case (state_q)
      S_INIT: begin
        ARF_RSel = 4'b1100;
        RF_RSel  = 4'b1111;
        RF_TSel  = 4'b1111;
        state_d  = S_F0;
      end
      S_F0: begin
`ifdef CU_SINGLE_STEP_EN
        // Step gates this cycle's fetch directly so a held Step keeps normal timing.
        if (Step) begin
`endif
          Mem_CS     = 1'b0;
          IR_Enable  = 1'b1;
          IR_FunSel  = 2'b01;
          ARF_FunSel = 2'b10;
          ARF_RSel   = 4'b1000;
          state_d    = S_F1;
`ifdef CU_SINGLE_STEP_EN
        end
`endif
      end
      S_F1: begin
        Mem_CS     = 1'b0;
        IR_Enable  = 1'b1;
        IR_FunSel  = 2'b01;
        IR_LH      = 1'b1;
        ARF_FunSel = 2'b10;
        ARF_RSel   = 4'b1000;
        state_d    = S_E0;
      end
      S_E0: begin
        state_d = S_E1;
        case (opcode)
          4'h0: begin
            MuxASel   = 2'b10;
            RF_FunSel = 2'b01;
            RF_RSel   = rd_onehot;
            InstrDone = 1'b1;
            state_d   = S_F0;
          end
          4'h1, 4'h2: begin
            MuxBSel     = 2'b10;
            ARF_FunSel  = 2'b01;
            ARF_RSel    = 4'b0100;
            ARF_OutBSel = 2'b00;
            if (opcode == 4'h2) RF_O1Sel = rd_sel;
          end
          4'hC, 4'hD: begin
            RF_FunSel = (opcode == 4'hC) ? 2'b11 : 2'b10;
            RF_RSel   = rd_onehot;
            InstrDone = 1'b1;
            state_d   = S_F0;
          end
          4'hE, 4'hF: begin
            if (opcode == 4'hE || !Z) begin
              MuxBSel    = 2'b10;
              ARF_FunSel = 2'b01;
              ARF_RSel   = 4'b1000;
            end
            InstrDone = 1'b1;
            state_d   = S_F0;
          end
          default: begin
            RF_O1Sel = rd_sel;
            RF_O2Sel = rs_sel;
          end
        endcase
      end
      S_E1: begin
        state_d = S_E2;
        if (opcode == 4'h1) begin
          ARF_OutBSel = 2'b00;
        end else if (opcode == 4'h2) begin
          ARF_OutBSel = 2'b00;
          RF_O1Sel    = rd_sel;
        end else if (is_alu_op) begin
          RF_O1Sel   = rd_sel;
          RF_O2Sel   = rs_sel;
          ALU_FunSel = alu_code;
        end else begin
          state_d = S_F0;
        end
      end
      S_E2: begin
        state_d = S_E3;
        if (opcode == 4'h1) begin
          ARF_OutBSel = 2'b00;
          Mem_CS      = 1'b0;
          MuxASel     = 2'b01;
          RF_FunSel   = 2'b01;
          RF_RSel     = rd_onehot;
        end else if (opcode == 4'h2) begin
          ARF_OutBSel = 2'b00;
          Mem_CS      = 1'b0;
          Mem_WR      = 1'b1;
        end else begin
          if (is_alu_op) begin
            RF_FunSel = 2'b01;
            RF_RSel   = rd_onehot;
            InstrDone = 1'b1;
          end
          state_d = S_F0;
        end
      end
      S_E3: begin
        InstrDone = 1'b1;
        state_d   = S_F0;
      end
      default: state_d = S_INIT;
    endcase
  end

endmodule
